leading_one_normalizer: RTL

Pipelined, handshaked leading-one detector and normaliser for the softmax ln path. It accepts one unsigned fixed-point word per cycle and finds the most-significant set bit. It returns:
- the 1-based position of that bit, plus its one-hot mask;
- the signed binary exponent relative to the fixed-point scale;
- the word left-shifted so the leading one sits at the MSB (mantissa for the ln LUT/polynomial).

It sits between the output buffer and the ln mantissa evaluator. It has valid/ready flow control on both sides and a pass-through tag.

---
 rtl/leading_one_normalizer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/leading_one_normalizer.sv
// leading_one_normalizer
//
// Two-stage pipelined leading-one detector / normaliser for the softmax ln path.
// For each unsigned fixed-point word F it returns the 1-based position of the most
// significant set bit, its one-hot mask, the signed binary exponent relative to the
// fixed-point scale, and F shifted left so the leading one lands on the MSB.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_data (F) and in_tag accepted on in_valid & in_ready
//   out_valid/ready output handshake; result held stable while out_valid & ~out_ready
//   out_pos         1-based leading-one index (0 when F == 0)
//   out_one_hot     mask of the leading-one bit (0 when F == 0)
//   out_exp         signed exponent out_pos - 1 - FRAC_W, POS_W+1 bits (0 when F == 0)
//   out_norm        F << (DATA_W - out_pos) (0 when F == 0)
//   out_zero        F was zero
//   out_tag         sideband tag carried with the word
module leading_one_normalizer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = 16,
   parameter int unsigned POS_W  = 6,
   parameter int unsigned TAG_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [POS_W-1:0]    out_pos,
   output logic [DATA_W-1:0]   out_one_hot,
   output logic [POS_W:0]      out_exp,
   output logic [DATA_W-1:0]   out_norm,
   output logic                out_zero,
   output logic [TAG_W-1:0]    out_tag
);

   localparam int unsigned EXP_W = POS_W + 1;

   // Stage 1 state
   logic                s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0]   s1_data_q, s1_data_d;
   logic [DATA_W-1:0]   s1_one_hot_q, s1_one_hot_d;
   logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
   logic                s1_zero_q, s1_zero_d;

   // Stage 2 state (drives the outputs directly)
   logic                s2_valid_q, s2_valid_d;
   logic [POS_W-1:0]    s2_pos_q, s2_pos_d;
   logic [DATA_W-1:0]   s2_one_hot_q, s2_one_hot_d;
   logic [EXP_W-1:0]    s2_exp_q, s2_exp_d;
   logic [DATA_W-1:0]   s2_norm_q, s2_norm_d;
   logic                s2_zero_q, s2_zero_d;
   logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;

   logic                s1_en, s2_en;
   logic [DATA_W-1:0]   in_one_hot;
   logic [POS_W-1:0]    pos_c;
   logic [EXP_W-1:0]    exp_c;
   logic [EXP_W-1:0]    shamt_c;
   logic [DATA_W-1:0]   norm_c;

   // Ready chain: a stage may load when it is empty or its successor is loading.
   assign s2_en    = ~s2_valid_q | out_ready;
   assign s1_en    = ~s1_valid_q | s2_en;
   assign in_ready = s1_en;

   // Leading-one mask: keep bit i only if no higher bit is set. 'seen' is the running
   // OR of all bits above i.
   always_comb begin
      logic seen;
      seen       = 1'b0;
      in_one_hot = '0;
      for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
         in_one_hot[i] = in_data[i] & ~seen;
         seen          = seen | in_data[i];
      end
   end

   // Stage 2 datapath: encode the one-hot mask, derive exponent and normalised word.
   always_comb begin
      pos_c = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (s1_one_hot_q[i]) begin
            pos_c = POS_W'(i + 1);
         end
      end
      // Modular subtraction in EXP_W bits yields the two's-complement exponent.
      exp_c   = {1'b0, pos_c} - EXP_W'(FRAC_W + 1);
      shamt_c = EXP_W'(DATA_W) - {1'b0, pos_c};
      norm_c  = s1_data_q << shamt_c;
      if (s1_zero_q) begin
         pos_c  = '0;
         exp_c  = '0;
         norm_c = '0;
      end
   end

   // Next-state for both stages
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_data_d    = s1_data_q;
      s1_one_hot_d = s1_one_hot_q;
      s1_tag_d     = s1_tag_q;
      s1_zero_d    = s1_zero_q;
      s2_valid_d   = s2_valid_q;
      s2_pos_d     = s2_pos_q;
      s2_one_hot_d = s2_one_hot_q;
      s2_exp_d     = s2_exp_q;
      s2_norm_d    = s2_norm_q;
      s2_zero_d    = s2_zero_q;
      s2_tag_d     = s2_tag_q;

      if (s1_en) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d    = in_data;
            s1_one_hot_d = in_one_hot;
            s1_tag_d     = in_tag;
            s1_zero_d    = (in_data == '0);
         end
      end

      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_pos_d     = pos_c;
            s2_one_hot_d = s1_one_hot_q;
            s2_exp_d     = exp_c;
            s2_norm_d    = norm_c;
            s2_zero_d    = s1_zero_q;
            s2_tag_d     = s1_tag_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_one_hot_q <= '0;
         s1_tag_q     <= '0;
         s1_zero_q    <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_pos_q     <= '0;
         s2_one_hot_q <= '0;
         s2_exp_q     <= '0;
         s2_norm_q    <= '0;
         s2_zero_q    <= 1'b0;
         s2_tag_q     <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s1_one_hot_q <= s1_one_hot_d;
         s1_tag_q     <= s1_tag_d;
         s1_zero_q    <= s1_zero_d;
         s2_valid_q   <= s2_valid_d;
         s2_pos_q     <= s2_pos_d;
         s2_one_hot_q <= s2_one_hot_d;
         s2_exp_q     <= s2_exp_d;
         s2_norm_q    <= s2_norm_d;
         s2_zero_q    <= s2_zero_d;
         s2_tag_q     <= s2_tag_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_pos     = s2_pos_q;
   assign out_one_hot = s2_one_hot_q;
   assign out_exp     = s2_exp_q;
   assign out_norm    = s2_norm_q;
   assign out_zero    = s2_zero_q;
   assign out_tag     = s2_tag_q;

endmodule
